// File: rtl/pool_window_sequencer_if.sv
// Stream-side signal bundle for the 3x3 pooling window sequencer.
// The slave view belongs to the sequencer. The master view belongs to whatever feeds and drains it.
interface pool_window_sequencer_if #(
    parameter int DW = 8
);
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/pool_window_sequencer.sv
// Buffers one IMG x IMG frame, then scans every WIN x WIN stride-1 window one element per cycle.
// It emits one max or average result per window, with valid/ready backpressure on the output.
module pool_window_sequencer #(
    parameter int DW  = 8,
    parameter int IMG = 8,
    parameter int WIN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    pool_window_sequencer_if.slave bus
);
    localparam int CW  = (IMG > 1) ? $clog2(IMG) : 1;
    localparam int AW  = (IMG > 1) ? $clog2(IMG * IMG) : 1;
    localparam int ACW = DW + 4;
    localparam logic [CW-1:0]  POS_LAST   = CW'(IMG - 1);
    localparam logic [CW-1:0]  WIN_LAST   = CW'(IMG - WIN);
    localparam logic [CW-1:0]  EL_LAST    = CW'(WIN - 1);
    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    localparam logic [CW-1:0]  C_ZERO     = CW'(0);
    localparam logic [AW-1:0]  ROW_STRIDE = AW'(IMG);
    localparam logic [ACW-1:0] WIN_AREA   = ACW'(WIN * WIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   buf_r [IMG*IMG];
    logic [CW-1:0]   row_r, col_r, i_r, j_r, k_r, l_r;
    logic            mode_r;
    logic [ACW-1:0]  acc_r, acc_s, base_s, elem_ext_s, result_s;
    logic [AW-1:0]   wr_addr_s, rd_addr_s;
    logic [DW-1:0]   elem_s;
    logic            in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
    logic [DW-1:0]   out_data_r;
    logic            in_fire_s, out_fire_s, load_last_s, el_last_s, win_last_s;

    assign in_fire_s   = bus.in_valid & in_ready_r;
    assign out_fire_s  = out_valid_r & bus.out_ready;
    assign load_last_s = (row_r == POS_LAST) && (col_r == POS_LAST);
    assign el_last_s   = (k_r == EL_LAST) && (l_r == EL_LAST);
    assign win_last_s  = (i_r == WIN_LAST) && (j_r == WIN_LAST);
    assign wr_addr_s   = AW'(row_r) * ROW_STRIDE + AW'(col_r);
    assign rd_addr_s   = (AW'(i_r) + AW'(k_r)) * ROW_STRIDE + AW'(j_r) + AW'(l_r);
    assign elem_s      = buf_r[rd_addr_s];

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    // Frame buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            buf_r[wr_addr_s] <= bus.in_data;
        end
    end

    // Window accumulator: the first element of a window restarts the max or the sum
    always_comb begin
        elem_ext_s = {{(ACW-DW){1'b0}}, elem_s};
        if ((k_r == C_ZERO) && (l_r == C_ZERO)) begin
            base_s = {ACW{1'b0}};
        end else begin
            base_s = acc_r;
        end
        if (mode_r) begin
            acc_s = base_s + elem_ext_s;
        end else if (elem_ext_s > base_s) begin
            acc_s = elem_ext_s;
        end else begin
            acc_s = base_s;
        end
        if (mode_r) begin
            result_s = acc_s / WIN_AREA;
        end else begin
            result_s = acc_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) state_s = LOAD;
                else           state_s = IDLE;
            end
            LOAD: begin
                if (in_fire_s && load_last_s) state_s = SCAN;
                else                          state_s = LOAD;
            end
            SCAN: begin
                if (el_last_s) state_s = EMIT;
                else           state_s = SCAN;
            end
            EMIT: begin
                if (out_fire_s && win_last_s) state_s = IDLE;
                else if (out_fire_s)          state_s = SCAN;
                else                          state_s = EMIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Counters, latched mode, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r       <= C_ZERO;
            col_r       <= C_ZERO;
            i_r         <= C_ZERO;
            j_r         <= C_ZERO;
            k_r         <= C_ZERO;
            l_r         <= C_ZERO;
            mode_r      <= 1'b0;
            acc_r       <= {ACW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, LOAD: begin
                    if (in_fire_s) begin
                        if (state_r == IDLE) begin
                            mode_r <= bus.mode;
                            busy_r <= 1'b1;
                        end
                        if (load_last_s) begin
                            row_r      <= C_ZERO;
                            col_r      <= C_ZERO;
                            in_ready_r <= 1'b0;
                        end else if (col_r == POS_LAST) begin
                            col_r <= C_ZERO;
                            row_r <= row_r + C_ONE;
                        end else begin
                            col_r <= col_r + C_ONE;
                        end
                    end
                end
                SCAN: begin
                    acc_r <= acc_s;
                    if (el_last_s) begin
                        k_r         <= C_ZERO;
                        l_r         <= C_ZERO;
                        out_data_r  <= DW'(result_s);
                        out_valid_r <= 1'b1;
                        out_last_r  <= win_last_s;
                    end else if (l_r == EL_LAST) begin
                        l_r <= C_ZERO;
                        k_r <= k_r + C_ONE;
                    end else begin
                        l_r <= l_r + C_ONE;
                    end
                end
                EMIT: begin
                    if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        // The final handshake re-opens the input for the next frame
                        if (win_last_s) begin
                            i_r        <= C_ZERO;
                            j_r        <= C_ZERO;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else if (j_r == WIN_LAST) begin
                            j_r <= C_ZERO;
                            i_r <= i_r + C_ONE;
                        end else begin
                            j_r <= j_r + C_ONE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pool_window_sequencer.sv
// Randomised self-checking bench for pool_window_sequencer.
// Expected pooled results come from a direct window loop over the frame array.
module tb_pool_window_sequencer;
    localparam int DW   = 8;
    localparam int IMG  = 8;
    localparam int WIN  = 3;
    localparam int OUTE = IMG - WIN + 1;
    localparam int NWIN = OUTE * OUTE;
    localparam int NPIX = IMG * IMG;
    localparam int MONN = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pool_window_sequencer_if #(.DW(DW)) bus ();

    pool_window_sequencer #(.DW(DW), .IMG(IMG), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] frame    [NPIX];
    logic [7:0] exp_data [NWIN];

    // Output monitor: records handshaken results, valid rises, done pulses and protocol breaches
    int         n_got = 0, n_rise = 0, done_cnt = 0, hold_err = 0, ready_err = 0;
    logic [7:0] got_data [MONN];
    logic       got_last [MONN];
    int         rise_cyc [MONN];
    logic       prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last))
                hold_err <= hold_err + 1;
            if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1)
                ready_err <= ready_err + 1;
            if (bus.out_valid === 1'b1 && !prev_valid && n_rise < MONN) begin
                rise_cyc[n_rise] <= cyc;
                n_rise <= n_rise + 1;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && n_got < MONN) begin
                got_data[n_got] <= bus.out_data;
                got_last[n_got] <= bus.out_last;
                n_got <= n_got + 1;
            end
            if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
            prev_stall <= (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_valid <= (bus.out_valid === 1'b1);
            prev_data  <= bus.out_data;
            prev_last  <= bus.out_last;
        end
    end

    task automatic build_expected(input bit m);
        for (int wr = 0; wr < OUTE; wr++) begin
            for (int wc = 0; wc < OUTE; wc++) begin
                int mx = 0;
                int s = 0;
                for (int dr = 0; dr < WIN; dr++) begin
                    for (int dc = 0; dc < WIN; dc++) begin
                        int v = int'(frame[(wr + dr) * IMG + wc + dc]);
                        s = s + v;
                        if (v > mx) mx = v;
                    end
                end
                exp_data[wr * OUTE + wc] = m ? 8'(s / (WIN * WIN)) : 8'(mx);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int p = 0; p < NPIX; p++) frame[p] = 8'(p);
    endtask

    // Streams the frame; returns the cycle of the last accepted pixel and the number sent
    task automatic send_frame(input bit m, input bit gaps, input bit flip, output int last_t, output int sent);
        int  guard;
        bit  toggle;
        bit  v;
        bit  acc;
        sent   = 0;
        guard  = 0;
        toggle = 1'b0;
        last_t = 0;
        bus.mode = m;
        while (sent < NPIX && guard < 1000) begin
            v      = gaps ? toggle : 1'b1;
            toggle = ~toggle;
            bus.in_valid = v;
            bus.in_data  = frame[sent];
            acc = v && (bus.in_ready === 1'b1);
            if (acc) last_t = cyc;
            @(posedge clk); #1;
            if (acc) sent++;
            if (flip && sent >= NPIX / 2) bus.mode = ~m;
            guard++;
        end
        bus.in_valid = 1'b0;
    endtask

    // Drives out_ready until n results are taken; optional 5-cycle stall on one window
    task automatic drain(input int n, input int stall_win, input bit rnd, output int got, output int stalled);
        int base;
        int guard;
        base    = n_got;
        guard   = 0;
        stalled = 0;
        while (n_got - base < n && guard < 2000) begin
            if (stall_win >= 0 && n_got - base == stall_win && bus.out_valid === 1'b1 && stalled < 5) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else if (rnd) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        got = n_got - base;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
            bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset_values: got rdy=%b ov=%b od=%0d ol=%b busy=%b done=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done);
            errors++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max_ramp();
        int last_t, sent, got, st, b_got, b_rise, b_done;
        fill_ramp();
        build_expected(1'b0);
        b_got = n_got; b_rise = n_rise; b_done = done_cnt;
        send_frame(1'b0, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, -1, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sent !== NPIX || got !== NWIN) begin
            $display("FAIL max_ramp_count: sent=%0d got=%0d, want %0d %0d", sent, got, NPIX, NWIN); errors++;
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== exp_data[w] || got_last[b_got + w] !== (w == NWIN - 1)) begin
                $display("FAIL max_ramp win %0d: got %0d last=%b, want %0d last=%b",
                         w, got_data[b_got + w], got_last[b_got + w], exp_data[w], (w == NWIN - 1)); errors++;
            end
        end
        checks++;
        if (got_data[b_got] !== 8'd18 || got_data[b_got + NWIN - 1] !== 8'd63) begin
            $display("FAIL max_ramp_ends: got first=%0d last=%0d, want 18 63", got_data[b_got], got_data[b_got + NWIN - 1]); errors++;
        end
        checks++;
        if (rise_cyc[b_rise] - last_t !== 10) begin
            $display("FAIL latency: got %0d cycles, want 10", rise_cyc[b_rise] - last_t); errors++;
        end
        checks++;
        if (rise_cyc[b_rise + 1] - rise_cyc[b_rise] !== 10) begin
            $display("FAIL result_period: got %0d cycles, want 10", rise_cyc[b_rise + 1] - rise_cyc[b_rise]); errors++;
        end
        checks++;
        if (done_cnt - b_done !== 1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL max_ramp_done: got pulses=%0d busy=%b rdy=%b, want 1 0 1", done_cnt - b_done, bus.busy, bus.in_ready); errors++;
        end
    endtask

    task automatic test_avg_ramp();
        int last_t, sent, got, st, b_got;
        fill_ramp();
        build_expected(1'b1);
        b_got = n_got;
        send_frame(1'b1, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, -1, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== exp_data[w] || got_data[b_got + w] !== 8'((w / OUTE) * IMG + (w % OUTE) + 9)) begin
                $display("FAIL avg_ramp win %0d: got %0d, want %0d", w, got_data[b_got + w], exp_data[w]); errors++;
            end
        end
        checks++;
        if (got_data[b_got] !== 8'd9 || got_data[b_got + 5] !== 8'd14 || got_data[b_got + NWIN - 1] !== 8'd54) begin
            $display("FAIL avg_ramp_points: got %0d %0d %0d, want 9 14 54",
                     got_data[b_got], got_data[b_got + 5], got_data[b_got + NWIN - 1]); errors++;
        end
    endtask

    task automatic test_extremes();
        int last_t, sent, got, st, b_got;
        for (int p = 0; p < NPIX; p++) frame[p] = 8'd255;
        b_got = n_got;
        send_frame(1'b1, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, -1, 1'b0, got, st);
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== 8'd255) begin
                $display("FAIL avg_all255 win %0d: got %0d, want 255", w, got_data[b_got + w]); errors++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NPIX; p++) frame[p] = 8'd0;
        b_got = n_got;
        send_frame(1'b0, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, -1, 1'b0, got, st);
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== 8'd0 || got !== NWIN) begin
                $display("FAIL max_all0 win %0d: got %0d (count %0d), want 0", w, got_data[b_got + w], got); errors++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int last_t, sent, got, st, b_got, b_hold, b_ready;
        fill_ramp();
        build_expected(1'b0);
        b_got = n_got; b_hold = hold_err; b_ready = ready_err;
        send_frame(1'b0, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, 3, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (st !== 5 || hold_err - b_hold !== 0 || ready_err - b_ready !== 0) begin
            $display("FAIL backpressure_hold: stalls=%0d hold_breaks=%0d ready_breaks=%0d, want 5 0 0",
                     st, hold_err - b_hold, ready_err - b_ready); errors++;
        end
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== exp_data[w]) begin
                $display("FAIL backpressure win %0d: got %0d, want %0d", w, got_data[b_got + w], exp_data[w]); errors++;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int last_t, sent, got, st, b_got, b_done;
        fill_ramp();
        build_expected(1'b0);
        b_done = done_cnt;
        send_frame(1'b0, 1'b0, 1'b0, last_t, sent);
        drain(10, -1, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL pre_reset_scan: got busy=%b ov=%b, want 1 0", bus.busy, bus.out_valid); errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
            bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL mid_reset_values: got rdy=%b ov=%b od=%0d ol=%b busy=%b done=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done);
            errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - b_done !== 0) begin
            $display("FAIL reset_no_done: got %0d pulses, want 0", done_cnt - b_done); errors++;
        end
        b_got = n_got; b_done = done_cnt;
        send_frame(1'b0, 1'b0, 1'b0, last_t, sent);
        drain(NWIN, -1, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== exp_data[w]) begin
                $display("FAIL post_reset win %0d: got %0d, want %0d", w, got_data[b_got + w], exp_data[w]); errors++;
            end
        end
        checks++;
        if (done_cnt - b_done !== 1) begin
            $display("FAIL post_reset_done: got %0d pulses, want 1", done_cnt - b_done); errors++;
        end
    endtask

    task automatic test_gapped_mode_flip();
        int last_t, sent, got, st, b_got;
        fill_ramp();
        build_expected(1'b0);
        b_got = n_got;
        send_frame(1'b0, 1'b1, 1'b1, last_t, sent);
        bus.mode = 1'b0;
        drain(NWIN, -1, 1'b0, got, st);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < NWIN; w++) begin
            checks++;
            if (got_data[b_got + w] !== exp_data[w]) begin
                $display("FAIL gapped_flip win %0d: got %0d, want %0d", w, got_data[b_got + w], exp_data[w]); errors++;
            end
        end
    endtask

    task automatic test_random_frames();
        int last_t, sent, got, st, b_got, b_hold;
        bit m;
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < NPIX; p++) frame[p] = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            build_expected(m);
            b_got = n_got; b_hold = hold_err;
            send_frame(m, 1'($urandom_range(0, 1)), 1'b1, last_t, sent);
            drain(NWIN, -1, 1'b1, got, st);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (got !== NWIN || hold_err - b_hold !== 0) begin
                $display("FAIL random_frame %0d: got %0d results, %0d hold breaks, want %0d 0", f, got, hold_err - b_hold, NWIN); errors++;
            end
            for (int w = 0; w < NWIN; w++) begin
                checks++;
                if (got_data[b_got + w] !== exp_data[w]) begin
                    $display("FAIL random_frame %0d win %0d: got %0d, want %0d (mode %0b)", f, w, got_data[b_got + w], exp_data[w], m); errors++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_ramp();
        test_avg_ramp();
        test_extremes();
        test_backpressure();
        test_reset_mid_scan();
        test_gapped_mode_flip();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
